// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and the butterfly operand bundle used across the core.
package ntt_pkg;

  localparam int unsigned Q_DEFAULT     = 7681;
  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned TAG_W_DEFAULT = 8;

  // One butterfly's operands plus its sideband tag.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] x;
    logic [WIDTH_DEFAULT-1:0] y;
    logic [WIDTH_DEFAULT-1:0] w;
    logic [TAG_W_DEFAULT-1:0] tag;
  } bfly_t;

endpackage

// File: rtl/Barrett_Reduction.sv
// Combinational (a*b) mod Q for operands already reduced below Q, via Barrett reduction.
module Barrett_Reduction
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned Q     = Q_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned QB = $clog2(Q);
  localparam int unsigned K  = 2 * QB;
  localparam logic [K:0]   MU = (K+1)'((64'd1 << K) / 64'(Q));
  localparam logic [K-1:0] QK = K'(Q);

  logic [QB-1:0]    a_t;
  logic [QB-1:0]    b_t;
  logic [K-1:0]     prod;
  logic [2*K-1:0]   qmul;
  logic [K-1:0]     q_est;
  logic [K-1:0]     qq;
  logic [K-1:0]     r0;
  logic [K-1:0]     r1;
  logic [K-1:0]     r2;

  // Operands are < Q, so only the low QB bits carry information.
  assign a_t   = QB'(a_i);
  assign b_t   = QB'(b_i);
  assign prod  = K'(a_t) * K'(b_t);
  assign qmul  = (2*K)'(prod) * (2*K)'(MU);
  assign q_est = K'(qmul >> K);
  assign qq    = q_est * QK;
  assign r0    = prod - qq;

  // The quotient estimate undershoots by at most two, hence two corrections.
  assign r1 = (r0 >= QK) ? r0 - QK : r0;
  assign r2 = (r1 >= QK) ? r1 - QK : r1;

  assign result_o = WIDTH'(r2);

endmodule

// File: rtl/mod_add_sub.sv
// Combinational modular sum and difference of two residues below Q.
module mod_add_sub
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned Q     = Q_DEFAULT
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] diff_o
);

  localparam logic [WIDTH:0] QE = (WIDTH+1)'(Q);

  logic [WIDTH:0] x_e;
  logic [WIDTH:0] p_e;
  logic [WIDTH:0] s;
  logic [WIDTH:0] sum_full;
  logic [WIDTH:0] diff_full;

  assign x_e = {1'b0, x_i};
  assign p_e = {1'b0, p_i};
  assign s   = x_e + p_e;

  assign sum_full  = (s >= QE) ? s - QE : s;
  assign diff_full = (x_e >= p_e) ? x_e - p_e : x_e + QE - p_e;

  assign sum_o  = WIDTH'(sum_full);
  assign diff_o = WIDTH'(diff_full);

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Three-stage Cooley-Tukey butterfly: (x + w*y) mod Q and (x - w*y) mod Q with valid/ready.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned Q     = Q_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [TAG_W-1:0] out_tag
);

  logic             advance;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_x_q;
  logic [WIDTH-1:0] s1_y_q;
  logic [WIDTH-1:0] s1_w_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_x_q;
  logic [WIDTH-1:0] s2_p_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_a_q;
  logic [WIDTH-1:0] out_b_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] diff_d;

  // Whole pipeline moves as one; a held output freezes every stage behind it.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  Barrett_Reduction #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_barrett (
    .a_i      (s1_w_q),
    .b_i      (s1_y_q),
    .result_o (p_d)
  );

  mod_add_sub #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_add_sub (
    .x_i    (s2_x_q),
    .p_i    (s2_p_q),
    .sum_o  (sum_d),
    .diff_o (diff_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_w_q     <= '0;
      s1_tag_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_x_q     <= in_x;
      s1_y_q     <= in_y;
      s1_w_q     <= in_w;
      s1_tag_q   <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_p_q     <= '0;
      s2_tag_q   <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_x_q     <= s1_x_q;
      s2_p_q     <= p_d;
      s2_tag_q   <= s1_tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_tag_q   <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      out_a_q     <= sum_d;
      out_b_q     <= diff_d;
      out_tag_q   <= s2_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Directed vectors, stall/reset sequences and a randomized scoreboard run for the butterfly.
module tb_ntt_butterfly_pipe;
  import ntt_pkg::*;

  localparam longint unsigned QL = 64'd7681;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic [31:0] in_w = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [7:0]  out_tag;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  bfly_t exp_q[$];

  ntt_butterfly_pipe #(.WIDTH(32), .Q(7681), .TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_w      (in_w),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference butterfly straight from the modular definitions.
  function automatic longint unsigned prod_mod(input bfly_t e);
    return (longint'(e.w) * longint'(e.y)) % QL;
  endfunction
  function automatic longint unsigned ref_a(input bfly_t e);
    return (longint'(e.x) + prod_mod(e)) % QL;
  endfunction
  function automatic longint unsigned ref_b(input bfly_t e);
    return (longint'(e.x) + QL - prod_mod(e)) % QL;
  endfunction

  // Scoreboard: records accepts, checks every delivered output and hold stability.
  initial begin
    bit          held = 1'b0;
    logic [31:0] held_a = '0;
    logic [31:0] held_b = '0;
    logic [7:0]  held_tag = '0;
    bfly_t       e;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        held = 1'b0;
      end else begin
        chk("in_ready_rule", in_ready, (!out_valid || out_ready));
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_a", out_a, held_a);
          chk("hold_b", out_b, held_b);
          chk("hold_tag", out_tag, held_tag);
        end
        if (in_valid && in_ready) begin
          e.x = in_x; e.y = in_y; e.w = in_w; e.tag = in_tag;
          exp_q.push_back(e);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_out_a", out_a, ref_a(e));
            chk("sb_out_b", out_b, ref_b(e));
            chk("sb_out_tag", out_tag, e.tag);
            n_out++;
          end
        end
        held     = out_valid && !out_ready;
        held_a   = out_a;
        held_b   = out_b;
        held_tag = out_tag;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w,
                      input logic [7:0] tag);
    int tries = 0;
    bit ok    = 1'b0;
    in_x = x; in_y = y; in_w = w; in_tag = tag; in_valid = 1'b1;
    while (!ok) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      tries++;
      if (!ok && tries > 200) begin
        chk("send_timeout", 0, 1);
        ok = 1'b1;
      end
    end
  endtask

  // Counts clock edges from the accepting edge (inclusive) until out_valid appears.
  task automatic wait_out(output int edges);
    edges = 1;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!out_valid && edges < 20);
  endtask

  task automatic drain();
    int g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] w;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   lat;
    int   base;
    int   acc;
    int   cyc;
    int   stale;
    logic [7:0] tagc;

    tbl[0] = '{x: 100,  y: 4712, w: 4571, ea: 1128, eb: 6753};
    tbl[1] = '{x: 7680, y: 1,    w: 1,    ea: 0,    eb: 7679};
    tbl[2] = '{x: 0,    y: 5,    w: 1,    ea: 5,    eb: 7676};
    tbl[3] = '{x: 0,    y: 0,    w: 0,    ea: 0,    eb: 0};
    tbl[4] = '{x: 7680, y: 7680, w: 7680, ea: 0,    eb: 7679};
    tbl[5] = '{x: 1,    y: 7680, w: 1,    ea: 0,    eb: 2};
    tbl[6] = '{x: 3000, y: 2,    w: 2,    ea: 3004, eb: 2996};
    tbl[7] = '{x: 7680, y: 0,    w: 5,    ea: 7680, eb: 7680};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Directed vectors with exact latency
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      send(tbl[i].x, tbl[i].y, tbl[i].w, 8'(i + 1));
      in_valid = 1'b0;
      wait_out(lat);
      chk("vec_latency", lat, 3);
      chk("vec_out_a", out_a, tbl[i].ea);
      chk("vec_out_b", out_b, tbl[i].eb);
      chk("vec_out_tag", out_tag, i + 1);
      $display("vec %0d: x=%0d y=%0d w=%0d -> a=%0d b=%0d lat=%0d", i, tbl[i].x, tbl[i].y,
               tbl[i].w, out_a, out_b, lat);
    end
    @(negedge clk);
    drain();

    // 16 back-to-back items must leave as 16 consecutive outputs
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(32'((i * 37) % 7681), 32'((i * 101 + 3) % 7681), 32'((i * 59 + 7) % 7681), 8'(i));
        in_valid = 1'b0;
      end
      begin
        int g = 0;
        int cnt = 0;
        do begin @(posedge clk); #1; g++; end while (!out_valid && g < 50);
        while (out_valid && cnt < 40) begin
          chk("stream_tag", out_tag, cnt);
          cnt++;
          @(posedge clk);
          #1;
        end
        chk("stream_len", cnt, 16);
        $display("stream: %0d consecutive outputs", cnt);
      end
    join
    @(negedge clk);
    drain();

    // Stall for 5 cycles after the first of 6 outputs
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'(1000 + i * 500), 32'(7000 - i * 3), 32'(17 + i), 8'(100 + i));
        in_valid = 1'b0;
      end
      begin
        int g = 0;
        do begin @(negedge clk); g++; end while (!out_valid && g < 50);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) begin
          #1;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_delivered", n_out - base, 6);
    $display("stall: delivered %0d items", n_out - base);

    // Async reset with three items in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'(10 + i), 32'(20 + i), 32'(30 + i), 8'(200 + i));
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_out_a", out_a, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("no_stale_output", stale, 0);
    @(negedge clk);
    send(32'd100, 32'd4712, 32'd4571, 8'd77);
    in_valid = 1'b0;
    wait_out(lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_out_a", out_a, 1128);
    chk("post_rst_out_b", out_b, 6753);
    chk("post_rst_out_tag", out_tag, 77);
    $display("reset: stale=%0d new item latency=%0d", stale, lat);
    @(negedge clk);
    drain();

    // Randomized traffic against the reference model
    base = n_out;
    acc  = 0;
    cyc  = 0;
    tagc = '0;
    while (acc < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_x   = $urandom_range(0, 7680);
      in_y   = $urandom_range(0, 7680);
      in_w   = $urandom_range(0, 7680);
      in_tag = tagc;
      #1;
      if (in_valid && in_ready) begin
        acc++;
        tagc++;
      end
    end
    chk("random_accepted", acc, 10000);
    @(negedge clk);
    drain();
    chk("random_delivered", n_out - base, acc);
    $display("random: accepted %0d delivered %0d in %0d cycles", acc, n_out - base, cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
